// File: rtl/psx_btn_conditioner.sv
// Debounces the active-low PSX buttons and maps them onto an active-high N64 button word.
// Latency DEBOUNCE_CYCLES+2 edges from raw input to output; the output only loads while n64_busy is low.
module psx_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter bit CMODE_EN        = 1'b1
) (
  input  logic        sample_clk,
  input  logic        reset_n,
  input  logic [15:0] psx_btns,
  input  logic        n64_busy,
  output logic [15:0] n64_btns,
  output logic        btns_changed,
  output logic        btns_valid
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(DEBOUNCE_CYCLES + 1);

  logic [15:0]   raw_q;
  logic [15:0]   deb;
  logic [CW-1:0] cnt [16];
  logic [SW-1:0] settle_cnt;
  logic [15:0]   p;
  logic [15:0]   map;

  // Input register plus one saturating-free counter per button; the counter
  // restarts whenever the raw bit agrees with the debounced bit again.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_q <= 16'hFFFF;
      deb   <= 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      raw_q <= psx_btns;
      for (int i = 0; i < 16; i++) begin
        if (raw_q[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    p   = ~deb;
    map = '0;
    map[15] = p[1];
    map[14] = p[2];
    map[13] = p[6] | p[7];
    map[5]  = p[5];
    map[4]  = p[4];
    map[3]  = p[3];
    map[2]  = p[13];
    map[1]  = p[0];
    map[0]  = p[14];
    // Select turns the d-pad into a second set of C buttons.
    if (CMODE_EN && p[15]) begin
      map[3] = map[3] | p[11];
      map[2] = map[2] | p[9];
      map[1] = map[1] | p[8];
      map[0] = map[0] | p[10];
    end else begin
      map[11] = p[11];
      map[10] = p[9];
      map[9]  = p[8];
      map[8]  = p[10];
    end
    if (p[5] && p[4] && p[12]) begin
      map[7]  = 1'b1;
      map[12] = 1'b0;
    end else begin
      map[12] = p[12];
    end
  end

  // Holding the output while busy keeps one N64 poll response self-consistent.
  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      n64_btns     <= 16'h0000;
      btns_changed <= 1'b0;
    end else if (!n64_busy) begin
      n64_btns     <= map;
      btns_changed <= (map != n64_btns);
    end else begin
      btns_changed <= 1'b0;
    end
  end

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
      btns_valid <= 1'b0;
    end else if (!btns_valid) begin
      settle_cnt <= settle_cnt + SW'(1);
      if (settle_cnt == SETTLE_LAST) begin
        btns_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psx_btn_conditioner.sv
// Directed bench for psx_btn_conditioner with a scoreboard keyed on btns_changed pulses.
module tb_psx_btn_conditioner;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] psx_btns = 16'hFFFF;
  logic        n64_busy = 1'b0;
  logic [15:0] n64_btns;
  logic        btns_changed;
  logic        btns_valid;

  psx_btn_conditioner #(.DEBOUNCE_CYCLES(N), .CMODE_EN(1'b1)) dut (
    .sample_clk  (clk),
    .reset_n     (reset_n),
    .psx_btns    (psx_btns),
    .n64_busy    (n64_busy),
    .n64_btns    (n64_btns),
    .btns_changed(btns_changed),
    .btns_valid  (btns_valid)
  );

  always #5 clk = ~clk;

  // Edge count since the last reset release: edge 1 is the first posedge after release.
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every btns_changed pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && btns_changed) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_change: n64_btns=%h at edge %0d with nothing expected", n64_btns, cyc);
      end else begin
        mon_e = q.pop_front();
        check("n64_btns", {16'h0, n64_btns}, {16'h0, mon_e.val});
        check("change_edge", cyc, mon_e.due);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new raw word; with busy low the output updates at edge 2+N after it is first sampled.
  task automatic apply(input logic [15:0] psx, input logic [15:0] exp_val);
    psx_btns = psx;
    q.push_back('{exp_val, cyc + N + 2});
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d expected updates never seen", q.size());
      q.delete();
    end
  endtask

  task automatic press(input logic [15:0] psx, input logic [15:0] exp_val);
    if (exp_val != 16'h0000) apply(psx, exp_val);
    else psx_btns = psx;
    drain();
    step(N + 4);
    check("steady", {16'h0, n64_btns}, {16'h0, exp_val});
    if (exp_val != 16'h0000) apply(16'hFFFF, 16'h0000);
    else psx_btns = 16'hFFFF;
    drain();
    step(N + 4);
  endtask

  task automatic settle_check();
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      check("valid_timing", {31'h0, btns_valid}, {31'h0, (k >= N + 2)});
      check("idle_btns", {16'h0, n64_btns}, 32'h0);
    end
  endtask

  typedef struct {
    logic [15:0] psx;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[14] = '{
    '{16'hFFFE, 16'h0002}, '{16'hFFFB, 16'h4000}, '{16'hFF7F, 16'h2000},
    '{16'hFFBF, 16'h2000}, '{16'hDFFF, 16'h0004}, '{16'hBFFF, 16'h0001},
    '{16'hFBFF, 16'h0100}, '{16'hFDFF, 16'h0400}, '{16'hFEFF, 16'h0200},
    '{16'hEFFF, 16'h1000}, '{16'h7FFF, 16'h0000}, '{16'h7DFF, 16'h0004},
    '{16'h7EFF, 16'h0002}, '{16'h7BFF, 16'h0001}
  };

  initial begin
    #1;
    check("rst_btns", {16'h0, n64_btns}, 32'h0);
    check("rst_changed", {31'h0, btns_changed}, 32'h0);
    check("rst_valid", {31'h0, btns_valid}, 32'h0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    settle_check();
    step(1);

    // X press and release.
    apply(16'hFFFD, 16'h8000);
    drain();
    apply(16'hFFFF, 16'h0000);
    drain();
    step(4);

    // A 3-cycle glitch is rejected; a 4-cycle one gets through.
    psx_btns = 16'hFFFD;
    step(3);
    psx_btns = 16'hFFFF;
    step(12);
    check("glitch3_btns", {16'h0, n64_btns}, 32'h0);
    apply(16'hFFFD, 16'h8000);
    step(4);
    apply(16'hFFFF, 16'h0000);
    drain();
    step(4);

    // Up held, released while busy; output frozen until busy drops.
    apply(16'hF7FF, 16'h0800);
    drain();
    step(2);
    n64_busy = 1'b1;
    step(2);
    psx_btns = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      step(5);
      check("busy_hold", {16'h0, n64_btns}, 32'h0800);
    end
    q.push_back('{16'h0000, cyc + 1});
    n64_busy = 1'b0;
    drain();
    step(4);

    // C-mode and the reset combo.
    apply(16'h77FF, 16'h0008);
    drain();
    apply(16'hEFCF, 16'h00B0);
    drain();
    apply(16'hFFFF, 16'h0000);
    drain();
    step(4);

    foreach (vecs[i]) press(vecs[i].psx, vecs[i].exp);

    // Reset in the middle of a busy hold with a debounce in flight.
    apply(16'hFFFD, 16'h8000);
    drain();
    n64_busy = 1'b1;
    psx_btns = 16'hFFFF;
    step(2);
    #2 reset_n = 1'b0;
    q.delete();
    #1;
    check("arst_btns", {16'h0, n64_btns}, 32'h0);
    check("arst_changed", {31'h0, btns_changed}, 32'h0);
    check("arst_valid", {31'h0, btns_valid}, 32'h0);
    n64_busy = 1'b0;
    step(2);
    @(posedge clk);
    #2 reset_n = 1'b1;
    settle_check();
    step(N + 6);
    check("post_reset_btns", {16'h0, n64_btns}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
